// File: rtl/calc1_req_driver_if.sv
// Requester, calc1 and response signals of the calc1 request driver.
// The master view belongs to the driver; the slave view to requester/calc1.
interface calc1_req_driver_if;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_cmd;
  logic [31:0] req_op1;
  logic [31:0] req_op2;
  logic [3:0]  calc_cmd;
  logic [31:0] calc_data;
  logic [1:0]  calc_resp;
  logic [31:0] calc_out_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_code;
  logic        rsp_timeout;
  logic [15:0] txn_count;

  modport master (
    input  req_valid, req_cmd, req_op1, req_op2, calc_resp, calc_out_data, rsp_ready,
    output req_ready, calc_cmd, calc_data, rsp_valid, rsp_data, rsp_code, rsp_timeout, txn_count
  );

  modport slave (
    output req_valid, req_cmd, req_op1, req_op2, calc_resp, calc_out_data, rsp_ready,
    input  req_ready, calc_cmd, calc_data, rsp_valid, rsp_data, rsp_code, rsp_timeout, txn_count
  );
endinterface

// File: rtl/calc1_req_driver.sv
// Drives one calc1 request port: two-beat command/operand send, bounded
// wait for the response, then holds the result until the requester takes it.
module calc1_req_driver #(
  parameter int TIMEOUT_CYCLES = 10
) (
  input logic                 c_clk,
  input logic                 reset,
  calc1_req_driver_if.master  bus
);

  typedef enum logic [2:0] {IDLE, SEND1, SEND2, WAIT, HOLD} state_t;

  localparam logic [15:0] TO_CNT = 16'(TIMEOUT_CYCLES);

  state_t      state;
  state_t      next_state;
  logic [3:0]  cmd_q;
  logic [31:0] op1_q;
  logic [31:0] op2_q;
  logic [15:0] wait_cnt;

  logic        accept;
  logic        handshake;
  logic        resp_hit;
  logic        timeout_hit;

  logic [3:0]  calc_cmd_d;
  logic [31:0] calc_data_d;
  logic        req_ready_d;
  logic        rsp_valid_d;
  logic [31:0] rsp_data_d;
  logic [1:0]  rsp_code_d;
  logic        rsp_timeout_d;
  logic [15:0] wait_cnt_d;

  // req_ready is only high while in IDLE, so it qualifies the accept alone.
  assign accept      = bus.req_valid && bus.req_ready;
  assign handshake   = bus.rsp_valid && bus.rsp_ready;
  assign resp_hit    = (state == WAIT) && (bus.calc_resp != 2'd0);
  assign timeout_hit = (state == WAIT) && (bus.calc_resp == 2'd0) && (wait_cnt == TO_CNT);

  always_ff @(posedge c_clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = (bus.req_cmd != 4'd0) ? SEND1 : HOLD;
      SEND1:   next_state = SEND2;
      SEND2:   next_state = WAIT;
      WAIT:    if (resp_hit || timeout_hit) next_state = HOLD;
      HOLD:    if (handshake) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs are computed from the current state and registered, so the calc
  // beats and rsp_valid appear one cycle after the state that produced them.
  always_comb begin
    calc_cmd_d    = 4'd0;
    calc_data_d   = 32'd0;
    if (state == SEND1) begin
      calc_cmd_d  = cmd_q;
      calc_data_d = op1_q;
    end else if (state == SEND2) begin
      calc_data_d = op2_q;
    end
    req_ready_d   = (next_state == IDLE);
    rsp_valid_d   = (state == HOLD) && !handshake;
    rsp_data_d    = bus.rsp_data;
    rsp_code_d    = bus.rsp_code;
    rsp_timeout_d = bus.rsp_timeout;
    if (state == IDLE && accept && bus.req_cmd == 4'd0) begin
      rsp_data_d    = 32'd0;
      rsp_code_d    = 2'd2;
      rsp_timeout_d = 1'b0;
    end else if (resp_hit) begin
      rsp_data_d    = bus.calc_out_data;
      rsp_code_d    = bus.calc_resp;
      rsp_timeout_d = 1'b0;
    end else if (timeout_hit) begin
      rsp_data_d    = 32'd0;
      rsp_code_d    = 2'd0;
      rsp_timeout_d = 1'b1;
    end
    wait_cnt_d = wait_cnt;
    if (state == SEND2)                          wait_cnt_d = 16'd1;
    else if (state == WAIT && next_state == WAIT) wait_cnt_d = wait_cnt + 16'd1;
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      bus.calc_cmd    <= 4'd0;
      bus.calc_data   <= 32'd0;
      bus.req_ready   <= 1'b0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_data    <= 32'd0;
      bus.rsp_code    <= 2'd0;
      bus.rsp_timeout <= 1'b0;
      bus.txn_count   <= 16'd0;
      wait_cnt        <= 16'd0;
    end else begin
      bus.calc_cmd    <= calc_cmd_d;
      bus.calc_data   <= calc_data_d;
      bus.req_ready   <= req_ready_d;
      bus.rsp_valid   <= rsp_valid_d;
      bus.rsp_data    <= rsp_data_d;
      bus.rsp_code    <= rsp_code_d;
      bus.rsp_timeout <= rsp_timeout_d;
      wait_cnt        <= wait_cnt_d;
      if (handshake) bus.txn_count <= bus.txn_count + 16'd1;
    end
  end

  always_ff @(posedge c_clk) begin
    if (state == IDLE && accept) begin
      cmd_q <= bus.req_cmd;
      op1_q <= bus.req_op1;
      op2_q <= bus.req_op2;
    end
  end

endmodule

// File: tb/tb_calc1_req_driver.sv
// Directed bench for calc1_req_driver: vector table of whole transactions
// plus hand-written reset and stray-response sequences.
module tb_calc1_req_driver;

  localparam int TO = 10;

  logic c_clk;
  logic reset;
  int   checks;
  int   errors;
  logic [15:0] exp_txn;

  calc1_req_driver_if bus();

  calc1_req_driver #(.TIMEOUT_CYCLES(TO)) dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (bus)
  );

  initial c_clk = 1'b0;
  always #5 c_clk = ~c_clk;

  typedef struct {
    string       name;
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    int          reply;     // WAIT cycle carrying the model reply, 0 = silent
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          hold;      // cycles rsp_ready stays low while rsp_valid is up
    logic [31:0] exp_data;
    logic [1:0]  exp_code;
    logic        exp_to;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_rsp(input string name, input vec_t v);
    chk({name, " rsp_valid"},   32'(bus.rsp_valid), 32'd1);
    chk({name, " rsp_data"},    bus.rsp_data, v.exp_data);
    chk({name, " rsp_code"},    32'(bus.rsp_code), 32'(v.exp_code));
    chk({name, " rsp_timeout"}, 32'(bus.rsp_timeout), 32'(v.exp_to));
    chk({name, " req_ready"},   32'(bus.req_ready), 32'd0);
    chk({name, " calc_cmd"},    32'(bus.calc_cmd), 32'd0);
  endtask

  // Starts one cycle before the accept edge with req_ready already high.
  task automatic run_txn(input vec_t v);
    chk({v.name, " ready before"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_cmd   = v.cmd;
    bus.req_op1   = v.op1;
    bus.req_op2   = v.op2;
    tick();
    bus.req_valid = 1'b0;
    bus.req_cmd   = 4'd0;
    bus.req_op1   = 32'd0;
    bus.req_op2   = 32'd0;
    chk({v.name, " ready after accept"}, 32'(bus.req_ready), 32'd0);
    chk({v.name, " valid after accept"}, 32'(bus.rsp_valid), 32'd0);
    if (v.cmd == 4'd0) begin
      chk({v.name, " cmd0 calc_cmd"}, 32'(bus.calc_cmd), 32'd0);
      tick();
    end else begin
      tick();
      chk({v.name, " send1 cmd"},  32'(bus.calc_cmd), 32'(v.cmd));
      chk({v.name, " send1 data"}, bus.calc_data, v.op1);
      tick();
      for (int k = 1; k <= TO; k++) begin
        chk({v.name, " wait cmd"},   32'(bus.calc_cmd), 32'd0);
        chk({v.name, " wait data"},  bus.calc_data, (k == 1) ? v.op2 : 32'd0);
        chk({v.name, " wait valid"}, 32'(bus.rsp_valid), 32'd0);
        if (k == v.reply) begin
          bus.calc_resp     = v.resp;
          bus.calc_out_data = v.rdata;
        end
        tick();
        bus.calc_resp     = 2'd0;
        bus.calc_out_data = 32'd0;
        if (k == v.reply || k == TO) break;
      end
      chk({v.name, " valid lag"}, 32'(bus.rsp_valid), 32'd0);
      tick();
    end
    for (int d = 0; d < v.hold; d++) begin
      chk_rsp({v.name, " held"}, v);
      tick();
    end
    chk_rsp(v.name, v);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    exp_txn = exp_txn + 16'd1;
    chk({v.name, " valid drop"}, 32'(bus.rsp_valid), 32'd0);
    chk({v.name, " txn_count"},  32'(bus.txn_count), 32'(exp_txn));
    chk({v.name, " ready again"}, 32'(bus.req_ready), 32'd1);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " calc_cmd"},    32'(bus.calc_cmd), 32'd0);
    chk({name, " calc_data"},   bus.calc_data, 32'd0);
    chk({name, " rsp_valid"},   32'(bus.rsp_valid), 32'd0);
    chk({name, " rsp_data"},    bus.rsp_data, 32'd0);
    chk({name, " rsp_code"},    32'(bus.rsp_code), 32'd0);
    chk({name, " rsp_timeout"}, 32'(bus.rsp_timeout), 32'd0);
    chk({name, " txn_count"},   32'(bus.txn_count), 32'd0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_txn = 16'd0;
    //           name        cmd  op1           op2           rpl rsp  rdata         hold exp_data      code to
    vecs[0] = '{"sub",       4'd2, 32'h1FFFFFFF, 32'h00000007, 3,  2'd1, 32'h1FFFFFF8, 0, 32'h1FFFFFF8, 2'd1, 1'b0};
    vecs[1] = '{"underflow", 4'd2, 32'h00080000, 32'h00100000, 2,  2'd2, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 2'd2, 1'b0};
    vecs[2] = '{"timeout",   4'd1, 32'h00000005, 32'h00000006, 0,  2'd0, 32'h0,        0, 32'h0,        2'd0, 1'b1};
    vecs[3] = '{"resp_wins", 4'd5, 32'h00000001, 32'h00000004, 10, 2'd1, 32'h00000010, 0, 32'h00000010, 2'd1, 1'b0};
    vecs[4] = '{"backpress", 4'd6, 32'h00000080, 32'h00000003, 1,  2'd1, 32'h00000010, 5, 32'h00000010, 2'd1, 1'b0};
    vecs[5] = '{"cmd0",      4'd0, 32'h12345678, 32'h9ABCDEF0, 0,  2'd0, 32'h0,        0, 32'h0,        2'd2, 1'b0};
    vecs[6] = '{"passthru",  4'd9, 32'hCAFE0000, 32'h0000BABE, 1,  2'd3, 32'hDEADBEEF, 2, 32'hDEADBEEF, 2'd3, 1'b0};

    reset             = 1'b1;
    bus.req_valid     = 1'b0;
    bus.req_cmd       = 4'd0;
    bus.req_op1       = 32'd0;
    bus.req_op2       = 32'd0;
    bus.calc_resp     = 2'd0;
    bus.calc_out_data = 32'd0;
    bus.rsp_ready     = 1'b0;
    tick();
    tick();
    chk_all_zero("reset");
    chk("reset req_ready", 32'(bus.req_ready), 32'd0);
    reset = 1'b0;
    // Stray calc1 reply while idle must be ignored.
    bus.calc_resp     = 2'd1;
    bus.calc_out_data = 32'h55AA55AA;
    tick();
    bus.calc_resp     = 2'd0;
    bus.calc_out_data = 32'd0;
    chk("first ready", 32'(bus.req_ready), 32'd1);
    tick();
    chk("stray resp valid", 32'(bus.rsp_valid), 32'd0);
    chk("stray resp data",  bus.rsp_data, 32'd0);

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Reset while waiting on calc1, then a late reply arrives.
    bus.req_valid = 1'b1;
    bus.req_cmd   = 4'd2;
    bus.req_op1   = 32'h00000100;
    bus.req_op2   = 32'h00000001;
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_txn = 16'd0;
    chk_all_zero("mid reset");
    chk("mid reset req_ready", 32'(bus.req_ready), 32'd0);
    tick();
    chk("post reset ready", 32'(bus.req_ready), 32'd1);
    bus.calc_resp     = 2'd1;
    bus.calc_out_data = 32'h000000FF;
    tick();
    bus.calc_resp     = 2'd0;
    bus.calc_out_data = 32'd0;
    tick();
    chk_all_zero("late reply");
    tick();
    chk("late reply valid", 32'(bus.rsp_valid), 32'd0);
    run_txn(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
